widrow_update_engine: RTL
=========================

# widrow_update_engine

Parametrised Widrow-Hoff weight-update engine: the next generation of the 4-bit single-delta learning block. It deserialises a Y_W-bit neuron output, forms the scaled error against a target, and applies the update to a register file of N_IN signed weights, one per input pixel. It adds a start/busy/done handshake, a per-channel update stream, selectable alpha (1 to 1/8), saturating weight accumulation and a weight clear. It sits between the serial neuron output and the weight store of the perceptron datapath.

## Interface
- N_IN, 4: number of input channels/weights (≥2)
- Y_W, 4: width of target d and serial output y
- W_W, 8: signed weight width; must satisfy W_W ≥ Y_W+2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin one learning step (honoured in IDLE only)
- clr  in  1  zero all weights (honoured in IDLE only)
- y  in  1  serial neuron output, MSB first
- d  in  Y_W  target, unsigned, sampled on accepted start
- pixel  in  N_IN  binary inputs, sampled on accepted start
- sel  in  2  alpha = 2^-sel, sampled on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at end of step
- dw_valid  out  1  high during per-channel update cycles
- dw_idx  out  clog2(N_IN)  channel of current dw
- dw  out  W_W  signed applied delta for channel dw_idx
- w  out  N_IN*W_W  flattened weights, channel 0 in LSBs

## Operation
- States: IDLE, SHIFT, ERR, UPD, DONE.
- IDLE: clr=1 zeros all weights; clr wins over simultaneous start, so that start is dropped. start=1 latches d, pixel and sel, clears the y shift register and the counter, then moves to SHIFT.
- SHIFT: each cycle, y_sr <= {y_sr[Y_W-2:0], y}. After Y_W cycles, move to ERR.
- ERR: e = (zext(d) - zext(y_sr)) << 1, signed, Y_W+2 bits, no overflow possible. m = e >>> sel (arithmetic shift, floor rounding). Move to UPD with idx=0.
- UPD: one channel per cycle. dw = pixel[idx] ? sext(m) : 0. w[idx] <= sat(w[idx] + dw), clamped to [-2^(W_W-1), 2^(W_W-1)-1]. dw_valid=1. After idx = N_IN-1, move to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- start and clr outside IDLE are ignored with no effect. Inputs latched at start are immune to later changes.
- Reset, asynchronous and valid in any state: state=IDLE, all weights 0, y_sr 0, counters 0. This includes reset mid-step; no partial update survives.

## Timing
- Reset values: busy=0, done=0, dw_valid=0, dw_idx=0, dw=0, w=0.
- Accepted start at cycle 0. y bits are sampled at cycles 1..Y_W (MSB at cycle 1). ERR is at cycle Y_W+1. UPD runs at cycles Y_W+2 .. Y_W+1+N_IN. done is at cycle Y_W+2+N_IN. Total latency is Y_W+N_IN+2 cycles.
- busy is asserted from cycle 1 through the UPD cycles; it is low in the done cycle.
- dw, dw_idx and dw_valid are registered and describe the update written on the same edge. w reflects the update one cycle after each UPD cycle.
- Earliest next accepted start is the cycle after done.
- Outside UPD, dw=0 and dw_valid=0.

## Structure
- The shared package widrow_pkg holds:
  - the state enum (IDLE, SHIFT, ERR, UPD, DONE);
  - the ALPHA_1/2/4/8 sel encodings (0..3);
  - a helper function for the saturation limits.
- Sub-module widrow_sat_add: a parametrised W_W signed saturating adder, instantiated once and time-shared across channels via idx.
- The FSM, the shift register and the weight register file live in the top module.

## Test plan
All scenarios use N_IN=4, Y_W=4, W_W=8.
- Reset: assert rst=0 mid-SHIFT after one prior step -> all outputs 0 immediately, w=0, next start is accepted normally.
- Basic: d=8, y=0,0,1,1, sel=0, pixel=1111 -> dw=10 on idx 0..3, w={10,10,10,10}, done exactly at cycle 10.
- Alpha and mask: d=8, y=3, sel=1, pixel=0101 -> dw=5,0,5,0, w0=w2=5, w1=w3=0.
- Negative error: d=2, y=1111, sel=2, pixel=0001 -> e=-26, dw=-7 (0xF9), w0=-7.
- Saturation: 5 steps with d=15, y=0, sel=0, pixel=1111 -> w=30,60,90,120, then 127 (clamped). Then d=0, y=15 repeated -> clamps at -128.
- Handshake: start pulses during busy are ignored, and the done count equals the accepted start count. clr+start in IDLE -> w=0, no step runs, busy stays 0.

Source files
------------

// File: rtl/widrow_pkg.sv
// Shared types and helpers for the Widrow-Hoff weight-update engine.
package widrow_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    ERR   = 3'd2,
    UPD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // sel encodings: alpha = 2^-sel
  localparam logic [1:0] ALPHA_1 = 2'd0;
  localparam logic [1:0] ALPHA_2 = 2'd1;
  localparam logic [1:0] ALPHA_4 = 2'd2;
  localparam logic [1:0] ALPHA_8 = 2'd3;

  // Largest value representable in a ww-bit two's complement word
  function automatic longint sat_hi(input int unsigned ww);
    return (longint'(1) <<< (ww - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a ww-bit two's complement word
  function automatic longint sat_lo(input int unsigned ww);
    return -(longint'(1) <<< (ww - 1));
  endfunction

endpackage

// File: rtl/widrow_sat_add.sv
// Signed saturating adder, clamps to the W-bit two's complement range.
module widrow_sat_add
  import widrow_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum_c
);

  localparam logic signed [W-1:0] MAXV = W'(sat_hi(W));
  localparam logic signed [W-1:0] MINV = W'(sat_lo(W));

  logic [W:0] raw;

  // One extra bit exposes overflow as disagreement of the top two bits
  always_comb begin
    raw = {a[W-1], a} + {b[W-1], b};
    if (raw[W] != raw[W-1]) begin
      sum_c = raw[W] ? MINV : MAXV;
    end else begin
      sum_c = raw[W-1:0];
    end
  end

endmodule

// File: rtl/widrow_update_engine.sv
// Widrow-Hoff weight update: deserialise y, form scaled error, update weights.
module widrow_update_engine
  import widrow_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned Y_W  = 4,
  parameter int unsigned W_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clr,
  input  logic                      y,
  input  logic [Y_W-1:0]            d,
  input  logic [N_IN-1:0]           pixel,
  input  logic [1:0]                sel,
  output logic                      busy,
  output logic                      done,
  output logic                      dw_valid,
  output logic [$clog2(N_IN)-1:0]   dw_idx,
  output logic signed [W_W-1:0]     dw,
  output logic [N_IN*W_W-1:0]       w
);

  localparam int unsigned IDX_W = $clog2(N_IN);
  localparam int unsigned E_W   = Y_W + 2;
  localparam int unsigned CNT_W = $clog2(Y_W);

  state_t                state;
  logic [Y_W-1:0]        d_r;
  logic [Y_W-1:0]        y_sr;
  logic [N_IN-1:0]       pixel_r;
  logic [1:0]            sel_r;
  logic [CNT_W-1:0]      cnt;
  logic signed [W_W-1:0] w_r [N_IN];

  logic signed [E_W-1:0] diff_c;
  logic signed [E_W-1:0] e_c;
  logic signed [E_W-1:0] m_c;
  logic signed [W_W-1:0] m_ext_c;
  logic signed [W_W-1:0] sum_c;

  // Scaled error; d_r, y_sr and sel_r stay frozen from ERR through UPD
  always_comb begin
    diff_c  = E_W'(d_r) - E_W'(y_sr);
    e_c     = diff_c <<< 1;
    m_c     = e_c >>> sel_r;
    m_ext_c = W_W'(m_c);
  end

  // Single adder shared by all channels, addressed by the current dw_idx
  widrow_sat_add #(.W(W_W)) u_sat_add (
    .a     (w_r[dw_idx]),
    .b     (dw),
    .sum_c (sum_c)
  );

  // Control FSM, y shift register, registered update stream and weight file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      d_r      <= '0;
      y_sr     <= '0;
      pixel_r  <= '0;
      sel_r    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dw_valid <= 1'b0;
      dw_idx   <= '0;
      dw       <= '0;
      for (int i = 0; i < N_IN; i++) w_r[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr) begin
            for (int i = 0; i < N_IN; i++) w_r[i] <= '0;
          end else if (start) begin
            d_r     <= d;
            pixel_r <= pixel;
            sel_r   <= sel;
            y_sr    <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          y_sr <= {y_sr[Y_W-2:0], y};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(Y_W - 1)) state <= ERR;
        end
        ERR: begin
          // Present channel 0's delta so it is visible during its UPD cycle
          dw_valid <= 1'b1;
          dw_idx   <= '0;
          dw       <= pixel_r[0] ? m_ext_c : '0;
          state    <= UPD;
        end
        UPD: begin
          w_r[dw_idx] <= sum_c;
          if (dw_idx == IDX_W'(N_IN - 1)) begin
            dw_valid <= 1'b0;
            dw_idx   <= '0;
            dw       <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            dw_idx <= dw_idx + IDX_W'(1);
            dw     <= pixel_r[dw_idx + IDX_W'(1)] ? m_ext_c : '0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Flatten the weight file, channel 0 in the LSBs
  for (genvar g = 0; g < N_IN; g++) begin : g_wout
    assign w[g*W_W +: W_W] = w_r[g];
  end

endmodule
